div_calculate: RTL

Multi-cycle 32-bit integer divider that executes DIV and DIVU for the multi-cycle MIPS core. It produces the quotient, which the control path writes to the Lo register, and the remainder, which is written to the Hi register. The control FSM stalls the instruction while `busy` is high and enables the Hi/Lo writes when `done` pulses. The divider uses a restoring radix-2 algorithm over magnitudes, with a final sign-fixup cycle.

---
 rtl/div_calculate.sv | 82 ++++++++
 1 files changed

// File: rtl/div_calculate.sv
// div_calculate: multi-cycle 32-bit restoring divider for DIV/DIVU (quotient -> Lo, remainder -> Hi)
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   start     : request a divide, sampled only when idle
//   is_signed : 1 = DIV (two's complement), 0 = DIVU
//   dividend  : rs operand, latched on an accepted start
//   divisor   : rt operand, latched on an accepted start
//   busy      : high while an operation is in flight
//   done      : one-cycle pulse when q/r are valid
//   q         : quotient
//   r         : remainder
module div_calculate (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] q,
   output logic [31:0] r
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t      state_q;
   logic        neg_a_q, neg_b_q;
   logic [31:0] dvs_q, quo_q, quo_d;
   logic [32:0] rem_q, rem_d, sh;
   logic [33:0] diff;
   logic [4:0]  cnt_q;
   // one restoring step: shift {rem, quo} left, trial-subtract, keep if no borrow
   always_comb begin
      sh    = {rem_q[31:0], quo_q[31]};
      diff  = {1'b0, sh} - {2'b0, dvs_q};
      rem_d = diff[33] ? sh : diff[32:0];
      quo_d = {quo_q[30:0], ~diff[33]};
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         q       <= '0;
         r       <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               neg_a_q <= is_signed & dividend[31];
               neg_b_q <= is_signed & divisor[31];
               quo_q   <= (is_signed & dividend[31]) ? -dividend : dividend;
               dvs_q   <= (is_signed & divisor[31]) ? -divisor : divisor;
               rem_q   <= '0;
               cnt_q   <= '0;
               busy    <= 1'b1;
               state_q <= CALC;
            end
            CALC: begin
               rem_q   <= rem_d;
               quo_q   <= quo_d;
               cnt_q   <= cnt_q + 5'd1;
               state_q <= (cnt_q == 5'd31) ? FIX : CALC;
            end
            FIX: begin
               // a zero divisor keeps the all-ones quotient; undoing the dividend
               // magnitude on the remainder returns the raw dividend
               q       <= ((neg_a_q ^ neg_b_q) && dvs_q != '0) ? -quo_q : quo_q;
               r       <= neg_a_q ? -rem_q[31:0] : rem_q[31:0];
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
endmodule
